// File: rtl/traffic_light_if.sv
// Junction-side signal bundle between the traffic controller and its environment.
// master drives the road/pedestrian inputs; slave is the controller itself.
`timescale 1ns/1ps
interface traffic_light_if;
    localparam int unsigned LIGHT_W = 3;
    localparam int unsigned PHASE_W = 3;

    logic               tick_src;
    logic               car_side;
    logic               ped_req;
    logic [LIGHT_W-1:0] main_light;
    logic [LIGHT_W-1:0] side_light;
    logic               walk;
    logic [PHASE_W-1:0] phase;

    modport master (
        output tick_src, car_side, ped_req,
        input  main_light, side_light, walk, phase
    );

    modport slave (
        input  tick_src, car_side, ped_req,
        output main_light, side_light, walk, phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Moore main/side junction controller timed by rising edges of the divider level tick_src.
// Lights and phase decode the state register; walk is registered on SIDE_GREEN entry.
`timescale 1ns/1ps
module traffic_light_ctrl #(
    parameter int unsigned T_MAIN_GREEN = 8,
    parameter int unsigned T_SIDE_GREEN = 5,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 1
) (
    input  logic            clk,
    input  logic            rst,
    traffic_light_if.slave  bus
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_e;

    // Held as plain bits so the unused codes 6/7 stay representable and recoverable.
    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick_prev_q;
    logic               ped_pending_q;
    logic               walk_q;

    logic               tick;
    logic               demand;
    logic               state_legal;
    logic [CNT_W-1:0]   cnt_last;
    state_e             seq_next;

    assign tick        = bus.tick_src & ~tick_prev_q;
    assign demand      = bus.car_side | ped_pending_q | bus.ped_req;
    assign state_legal = (state_q <= ALL_RED_B);

    // Last count value of the current phase and the phase that follows it.
    always_comb begin
        cnt_last = '0;
        seq_next = ALL_RED_B;
        case (state_q)
            MAIN_GREEN:  begin cnt_last = CNT_W'(T_MAIN_GREEN - 1); seq_next = MAIN_YELLOW; end
            MAIN_YELLOW: begin cnt_last = CNT_W'(T_YELLOW - 1);     seq_next = ALL_RED_A;   end
            ALL_RED_A:   begin cnt_last = CNT_W'(T_ALL_RED - 1);    seq_next = SIDE_GREEN;  end
            SIDE_GREEN:  begin cnt_last = CNT_W'(T_SIDE_GREEN - 1); seq_next = SIDE_YELLOW; end
            SIDE_YELLOW: begin cnt_last = CNT_W'(T_YELLOW - 1);     seq_next = ALL_RED_B;   end
            ALL_RED_B:   begin cnt_last = CNT_W'(T_ALL_RED - 1);    seq_next = MAIN_GREEN;  end
            default:     begin cnt_last = '0;                       seq_next = ALL_RED_B;   end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= MAIN_GREEN;
            cnt_q         <= '0;
            tick_prev_q   <= 1'b1;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            tick_prev_q <= bus.tick_src;
            if (bus.ped_req) begin
                ped_pending_q <= 1'b1;
            end
            if (!state_legal) begin
                state_q <= ALL_RED_B;
                cnt_q   <= '0;
            end else if (tick) begin
                if (cnt_q != cnt_last) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if ((state_q != MAIN_GREEN) || demand) begin
                    state_q <= seq_next;
                    cnt_q   <= '0;
                    // A request on the entry edge itself is served now rather than left pending.
                    if (seq_next == SIDE_GREEN) begin
                        walk_q        <= ped_pending_q | bus.ped_req;
                        ped_pending_q <= 1'b0;
                    end
                    if (state_q == SIDE_GREEN) begin
                        walk_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Light decode as {red, yellow, green}; anything not explicitly green/yellow shows red.
    always_comb begin
        bus.main_light = 3'b100;
        bus.side_light = 3'b100;
        case (state_q)
            MAIN_GREEN:  bus.main_light = 3'b001;
            MAIN_YELLOW: bus.main_light = 3'b010;
            SIDE_GREEN:  bus.side_light = 3'b001;
            SIDE_YELLOW: bus.side_light = 3'b010;
            default:     ;
        endcase
    end

    assign bus.phase = state_q;
    assign bus.walk  = walk_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: one task per scenario, expected phases hand-tabulated.
`timescale 1ns/1ps
module tb_traffic_light_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    traffic_light_if bus ();

    traffic_light_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_main(input logic [2:0] p);
        case (p)
            3'd0:    return 3'b001;
            3'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] p);
        case (p)
            3'd3:    return 3'b001;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic apply_reset();
        rst          = 1'b1;
        bus.tick_src = 1'b0;
        bus.car_side = 1'b0;
        bus.ped_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick_rise();
        @(negedge clk);
        bus.tick_src = 1'b1;
    endtask

    task automatic tick_tail();
        repeat (7) @(negedge clk);
        bus.tick_src = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_tick();
        tick_rise();
        @(negedge clk);
        tick_tail();
    endtask

    task automatic ped_pulse();
        @(negedge clk);
        bus.ped_req = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.tick_src = 1'b0;
        bus.car_side = 1'b0;
        bus.ped_req  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.phase, bus.main_light, bus.side_light, bus.walk} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset: got phase=%0d main=%b side=%b walk=%b, want 0/001/100/0",
                     bus.phase, bus.main_light, bus.side_light, bus.walk);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle();
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            do_tick();
            checks++;
            if ({bus.phase, bus.main_light, bus.side_light, bus.walk} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
                errors++;
                $display("FAIL idle tick %0d: got phase=%0d main=%b side=%b walk=%b, want 0/001/100/0",
                         k, bus.phase, bus.main_light, bus.side_light, bus.walk);
            end
        end
    endtask

    task automatic test_car_cycle();
        int          exp_ph [21] = '{0,0,0,0,0,0,0,1,1,1,2,3,3,3,3,3,4,4,4,5,0};
        logic [2:0]  prev;
        logic [2:0]  want;
        apply_reset();
        bus.car_side = 1'b1;
        prev = 3'd0;
        for (int k = 1; k <= 21; k++) begin
            want = 3'(exp_ph[k-1]);
            tick_rise();
            checks++;
            if (bus.phase !== prev) begin
                errors++;
                $display("FAIL car early tick %0d: got phase=%0d before clk edge, want %0d", k, bus.phase, prev);
            end
            @(negedge clk);
            checks++;
            if ({bus.phase, bus.main_light, bus.side_light, bus.walk} !== {want, exp_main(want), exp_side(want), 1'b0}) begin
                errors++;
                $display("FAIL car tick %0d: got phase=%0d main=%b side=%b walk=%b, want phase=%0d main=%b side=%b walk=0",
                         k, bus.phase, bus.main_light, bus.side_light, bus.walk, want, exp_main(want), exp_side(want));
            end
            prev = want;
            tick_tail();
        end
        bus.car_side = 1'b0;
    endtask

    task automatic test_ped_walk();
        int         exp_ph [14] = '{1,1,1,2,3,3,3,3,3,4,4,4,5,0};
        logic [2:0] want;
        logic       want_walk;
        apply_reset();
        repeat (20) do_tick();
        ped_pulse();
        for (int i = 0; i < 14; i++) begin
            do_tick();
            want      = 3'(exp_ph[i]);
            want_walk = (want == 3'd3);
            checks++;
            if ({bus.phase, bus.main_light, bus.side_light, bus.walk} !== {want, exp_main(want), exp_side(want), want_walk}) begin
                errors++;
                $display("FAIL ped tick %0d: got phase=%0d main=%b side=%b walk=%b, want phase=%0d walk=%b",
                         21 + i, bus.phase, bus.main_light, bus.side_light, bus.walk, want, want_walk);
            end
        end
        for (int i = 0; i < 10; i++) begin
            do_tick();
            checks++;
            if ({bus.phase, bus.walk} !== {3'd0, 1'b0}) begin
                errors++;
                $display("FAIL ped hold tick %0d: got phase=%0d walk=%b, want 0/0", i, bus.phase, bus.walk);
            end
        end
    endtask

    task automatic test_ped_mid_side();
        int         exp_ph [19] = '{3,3,4,4,4,5,0,0,0,0,0,0,0,0,1,1,1,2,3};
        logic [2:0] want;
        logic       want_walk;
        apply_reset();
        bus.car_side = 1'b1;
        repeat (12) do_tick();
        bus.car_side = 1'b0;
        checks++;
        if ({bus.phase, bus.walk} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL midside entry: got phase=%0d walk=%b, want 3/0", bus.phase, bus.walk);
        end
        repeat (2) do_tick();
        ped_pulse();
        for (int i = 0; i < 19; i++) begin
            do_tick();
            want      = 3'(exp_ph[i]);
            want_walk = (i == 18);
            checks++;
            if ({bus.phase, bus.walk} !== {want, want_walk}) begin
                errors++;
                $display("FAIL midside tick %0d: got phase=%0d walk=%b, want phase=%0d walk=%b",
                         15 + i, bus.phase, bus.walk, want, want_walk);
            end
        end
    endtask

    task automatic test_reset_mid_side();
        apply_reset();
        bus.car_side = 1'b1;
        repeat (10) do_tick();
        ped_pulse();
        repeat (2) do_tick();
        checks++;
        if ({bus.phase, bus.walk} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL rstmid pre: got phase=%0d walk=%b, want 3/1", bus.phase, bus.walk);
        end
        @(negedge clk);
        bus.tick_src = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.phase, bus.main_light, bus.side_light, bus.walk} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL rstmid async: got phase=%0d main=%b side=%b walk=%b, want 0/001/100/0",
                     bus.phase, bus.main_light, bus.side_light, bus.walk);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        bus.tick_src = 1'b0;
        repeat (8) @(negedge clk);
        repeat (7) do_tick();
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL rstmid spurious tick: got phase=%0d after 7 ticks, want 0", bus.phase);
        end
        do_tick();
        checks++;
        if (bus.phase !== 3'd1) begin
            errors++;
            $display("FAIL rstmid 8th tick: got phase=%0d, want 1", bus.phase);
        end
        bus.car_side = 1'b0;
    endtask

    task automatic test_hold_high();
        apply_reset();
        bus.car_side = 1'b1;
        tick_rise();
        repeat (100) @(negedge clk);
        bus.tick_src = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL hold high: got phase=%0d after held tick_src, want 0", bus.phase);
        end
        repeat (6) do_tick();
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL hold count: got phase=%0d after 7 total ticks, want 0", bus.phase);
        end
        do_tick();
        checks++;
        if (bus.phase !== 3'd1) begin
            errors++;
            $display("FAIL hold once: got phase=%0d after 8 total ticks, want 1", bus.phase);
        end
        bus.car_side = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        repeat (3) do_tick();
        @(negedge clk);
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        checks++;
        if ({bus.phase, bus.main_light, bus.side_light} !== {3'd7, 3'b100, 3'b100}) begin
            errors++;
            $display("FAIL illegal decode: got phase=%0d main=%b side=%b, want 7/100/100",
                     bus.phase, bus.main_light, bus.side_light);
        end
        @(negedge clk);
        checks++;
        if ({bus.phase, bus.main_light, bus.side_light} !== {3'd5, 3'b100, 3'b100}) begin
            errors++;
            $display("FAIL illegal recover: got phase=%0d main=%b side=%b, want 5/100/100",
                     bus.phase, bus.main_light, bus.side_light);
        end
        do_tick();
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL illegal count: got phase=%0d one tick after recovery, want 0", bus.phase);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.tick_src = 1'b0;
        bus.car_side = 1'b0;
        bus.ped_req  = 1'b0;
        test_reset();
        test_idle();
        test_car_cycle();
        test_ped_walk();
        test_ped_mid_side();
        test_reset_mid_side();
        test_hold_high();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Moore traffic-light controller for a main/side road junction with a pedestrian request input.
- Sits directly downstream of the team's clock divider and consumes its scaled_clk output on tick_src.
- tick_src is used only as a sampled enable inside the clk domain, never as a clock.
- Each rising edge of tick_src is one timing tick; phase durations are counted in ticks.

Parameters:
T_MAIN_GREEN, 8, minimum main-green duration in ticks (1..255)
T_SIDE_GREEN, 5, side-green duration in ticks (1..255)
T_YELLOW, 3, yellow duration in ticks for both roads (1..255)
T_ALL_RED, 1, all-red clearance duration in ticks (1..255)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  asynchronous, active-high reset
tick_src  input  1  divided-clock level from the frequency divider, synchronous to clk
car_side  input  1  level; a vehicle is waiting on the side road
ped_req  input  1  pedestrian request; sampled every clk, pulse or level
main_light  output  3  {red, yellow, green} for the main road
side_light  output  3  {red, yellow, green} for the side road
walk  output  1  pedestrian walk signal
phase  output  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - phase=0 (MAIN_GREEN), tick counter=0, ped_pending=0, walk=0.
  - tick_prev=1, so a high tick_src at reset release produces no tick.
  - main_light=001, side_light=100.
- Tick detection:
  - tick_prev <= tick_src on every clk edge.
  - tick = tick_src & ~tick_prev.
  - One tick per tick_src rising edge; tick_src held high produces no further ticks.
- States and light decode. Lights and phase are combinational decode of the state register (Moore):
  - 0 MAIN_GREEN: main 001, side 100
  - 1 MAIN_YELLOW: main 010, side 100
  - 2 ALL_RED_A: main 100, side 100
  - 3 SIDE_GREEN: main 100, side 001
  - 4 SIDE_YELLOW: main 100, side 010
  - 5 ALL_RED_B: main 100, side 100
- Tick counter:
  - 8-bit; cleared to 0 on every state change.
  - Updates only on clk edges where tick=1; otherwise state and counter hold.
- Timed states (1, 2, 3, 4, 5):
  - On a tick with count == T-1: advance to the next state (1->2->3->4->5->0).
  - Otherwise count++.
  - T is T_YELLOW for states 1 and 4, T_ALL_RED for 2 and 5, T_SIDE_GREEN for 3.
- MAIN_GREEN:
  - On a tick with count < T_MAIN_GREEN-1: count++.
  - On a tick with count == T_MAIN_GREEN-1: go to MAIN_YELLOW if (car_side | ped_pending | ped_req); otherwise hold, with the counter saturated at T_MAIN_GREEN-1.
  - With no demand, main green lasts indefinitely.
- Latency: the state changes on the same clk edge at which tick=1 is evaluated, i.e. one clk after tick_src rises.
- Pedestrian logic:
  - ped_pending <= 1 on any clk where ped_req=1, except on the SIDE_GREEN entry edge.
  - On the edge entering SIDE_GREEN: walk <= ped_pending | ped_req, and ped_pending <= 0.
  - walk stays constant for all of SIDE_GREEN and clears on the edge leaving SIDE_GREEN.
  - A ped_req arriving after SIDE_GREEN entry sets ped_pending and is served in the next cycle.
- Illegal phase (6, 7): on the next clk edge, regardless of tick, go to ALL_RED_B with count=0. Lights decode 100/100 while illegal.
- Reset mid-operation: all registers return to reset values immediately; no partial phase is resumed.
- Nominal divider input: tick_src toggles every 8 clk, giving one tick per 16 clk.

Test Plan:
- Reset, tick every 16 clk, car_side=0, ped_req=0 for 40 ticks -> phase stays 0, main_light=001, side_light=100, walk=0 throughout.
- car_side=1 from reset -> phase 0 for ticks 0-7, 1 entered at tick 8, 2 at tick 11, 3 at tick 12, 4 at tick 17, 5 at tick 20, 0 at tick 21; walk=0; each change lands 1 clk after the tick_src rise.
- car_side=0, 1-clk ped_req pulse at tick 20 -> MAIN_YELLOW on tick 21, SIDE_GREEN with walk=1 for exactly 5 ticks, walk=0 after; returns to phase 0 and then holds there (pending cleared).
- car_side=0, ped_req pulse at tick 2 of SIDE_GREEN -> walk keeps its entry value for this phase; after return to MAIN_GREEN and 8 ticks, a second cycle runs with walk=1 in SIDE_GREEN.
- rst asserted mid SIDE_GREEN with tick_src=1, released while tick_src still 1 -> phase=0, lights 001/100, walk=0 asynchronously; no tick until tick_src falls and rises again.
- tick_src held high for 100 clk after a rise -> counter advances exactly once.
- Force phase=7 via bench -> next clk phase=5, count=0; lights 100/100 throughout.
